// File: rtl/pixel_scan_gen_pkg.sv
// Shared OLED graphics constants and the scan-state encoding used by the pixel scan generator.
// Optional XY outputs of pixel_scan_gen are controlled by PIXEL_SCAN_XY_OUT_EN.
package pixel_scan_gen_pkg;

  localparam int OLED_WIDTH  = 96;
  localparam int OLED_HEIGHT = 64;
  localparam int OLED_PIXELS = OLED_WIDTH * OLED_HEIGHT;
  localparam int OLED_IDX_W  = 13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_BLANK = 2'd2
  } scan_state_t;

endpackage

// File: rtl/pixel_scan_gen_scan_xy_counter.sv
// Column/row counter pair that tracks the raster index without a divider.
// Only instantiated when PIXEL_SCAN_XY_OUT_EN is defined.
module scan_xy_counter
  import pixel_scan_gen_pkg::*;
#(
  parameter int WIDTH  = OLED_WIDTH,
  parameter int HEIGHT = OLED_HEIGHT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  output logic [7:0] pixel_x,
  output logic [7:0] pixel_y
);

  localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
  localparam logic [7:0] Y_LAST = 8'(HEIGHT - 1);

  // The last pixel of a frame is (X_LAST, Y_LAST), so both wrap back to 0 on its accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_x <= 8'd0;
      pixel_y <= 8'd0;
    end else if (advance) begin
      if (pixel_x == X_LAST) begin
        pixel_x <= 8'd0;
        pixel_y <= (pixel_y == Y_LAST) ? 8'd0 : pixel_y + 8'd1;
      end else begin
        pixel_x <= pixel_x + 8'd1;
      end
    end
  end

endmodule

// File: rtl/pixel_scan_gen.sv
// Raster-order pixel index source with valid/ready handshake, frame strobes and blanking gap.
// Define PIXEL_SCAN_XY_OUT_EN to add registered pixel_x/pixel_y outputs.
module pixel_scan_gen
  import pixel_scan_gen_pkg::*;
#(
  parameter int WIDTH        = OLED_WIDTH,
  parameter int HEIGHT       = OLED_HEIGHT,
  parameter int IDX_W        = OLED_IDX_W,
  parameter int BLANK_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pixel_ready,
  output logic             pixel_valid,
  output logic [IDX_W-1:0] pixel_index,
  output logic             frame_begin,
  output logic             frame_end,
  output logic [7:0]       frame_cnt,
  output logic             busy
`ifdef PIXEL_SCAN_XY_OUT_EN
  ,
  output logic [7:0]       pixel_x,
  output logic [7:0]       pixel_y
`endif
);

  localparam int               BLANK_W    = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(WIDTH * HEIGHT - 1);
  localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BLANK_CYCLES - 1);

  scan_state_t        state, state_nxt;
  logic [BLANK_W-1:0] blank_cnt;
  logic               accept;
  logic               last_accept;

  assign accept      = (state == ST_SCAN) && pixel_ready;
  assign last_accept = accept && (pixel_index == LAST_IDX);
  assign frame_begin = pixel_valid && (pixel_index == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Outputs decode only the state register, so pixel_ready never reaches pixel_valid.
  always_comb begin
    state_nxt   = state;
    pixel_valid = 1'b0;
    busy        = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (enable) state_nxt = ST_SCAN;
      end
      ST_SCAN: begin
        pixel_valid = 1'b1;
        if (last_accept) state_nxt = ST_BLANK;
      end
      ST_BLANK: begin
        if (blank_cnt == '0) state_nxt = enable ? ST_SCAN : ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Blank counter loads BLANK_CYCLES-1 so the gap is exactly BLANK_CYCLES clocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_index <= '0;
      blank_cnt   <= '0;
      frame_end   <= 1'b0;
      frame_cnt   <= 8'd0;
    end else begin
      frame_end <= last_accept;
      if (accept) pixel_index <= last_accept ? '0 : pixel_index + IDX_W'(1);
      if (last_accept) begin
        blank_cnt <= BLANK_LOAD;
        frame_cnt <= frame_cnt + 8'd1;
      end else if ((state == ST_BLANK) && (blank_cnt != '0)) begin
        blank_cnt <= blank_cnt - BLANK_W'(1);
      end
    end
  end

`ifdef PIXEL_SCAN_XY_OUT_EN
  scan_xy_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_xy (
    .clk     (clk),
    .reset   (reset),
    .advance (accept),
    .pixel_x (pixel_x),
    .pixel_y (pixel_y)
  );
`endif

endmodule

// File: tb/tb_pixel_scan_gen.sv
// Directed bench for pixel_scan_gen: full OLED instance plus a tiny 4x2, one-blank-clock instance.
// Covers the XY outputs as well when PIXEL_SCAN_XY_OUT_EN is defined.
module tb_pixel_scan_gen;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, enable, pixel_ready;
  logic        pixel_valid, frame_begin, frame_end, busy;
  logic [12:0] pixel_index;
  logic [7:0]  frame_cnt;

  logic        s_reset, s_enable, s_ready;
  logic        s_valid, s_frame_begin, s_frame_end, s_busy;
  logic [2:0]  s_idx;
  logic [7:0]  s_cnt;

`ifdef PIXEL_SCAN_XY_OUT_EN
  logic [7:0]  pixel_x, pixel_y, s_x, s_y;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  pixel_scan_gen u_dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .pixel_ready (pixel_ready),
    .pixel_valid (pixel_valid),
    .pixel_index (pixel_index),
    .frame_begin (frame_begin),
    .frame_end   (frame_end),
    .frame_cnt   (frame_cnt),
    .busy        (busy)
`ifdef PIXEL_SCAN_XY_OUT_EN
    ,
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y)
`endif
  );

  pixel_scan_gen #(
    .WIDTH        (4),
    .HEIGHT       (2),
    .IDX_W        (3),
    .BLANK_CYCLES (1)
  ) u_small (
    .clk         (clk),
    .reset       (s_reset),
    .enable      (s_enable),
    .pixel_ready (s_ready),
    .pixel_valid (s_valid),
    .pixel_index (s_idx),
    .frame_begin (s_frame_begin),
    .frame_end   (s_frame_end),
    .frame_cnt   (s_cnt),
    .busy        (s_busy)
`ifdef PIXEL_SCAN_XY_OUT_EN
    ,
    .pixel_x     (s_x),
    .pixel_y     (s_y)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad;
    int exp_idx;
    int accepts;
    int cycles;
    int fe_seen;

    reset = 1'b1; enable = 1'b0; pixel_ready = 1'b0;
    s_reset = 1'b1; s_enable = 1'b0; s_ready = 1'b0;
    repeat (3) step();

    chk("rst_valid", pixel_valid, 0);
    chk("rst_index", pixel_index, 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_end", frame_end, 0);
    chk("rst_frame_begin", frame_begin, 0);

    reset = 1'b0;
    step();
    chk("idle_no_enable", pixel_valid, 0);

    // Frame 1: ready always high.
    enable = 1'b1; pixel_ready = 1'b1;
    step();
    chk("valid_rise", pixel_valid, 1);
    chk("first_index", pixel_index, 0);
    chk("first_frame_begin", frame_begin, 1);
    chk("scan_busy", busy, 1);
    bad = 0;
    for (int i = 0; i < 6144; i++) begin
      if (pixel_valid !== 1'b1 || pixel_index !== 13'(i)) bad++;
      if (i > 0 && frame_begin !== 1'b0) bad++;
`ifdef PIXEL_SCAN_XY_OUT_EN
      if (i == 95)   begin chk("xy95_x", pixel_x, 95); chk("xy95_y", pixel_y, 0);  end
      if (i == 96)   begin chk("xy96_x", pixel_x, 0);  chk("xy96_y", pixel_y, 1);  end
      if (i == 6143) begin chk("xy_last_x", pixel_x, 95); chk("xy_last_y", pixel_y, 63); end
`endif
      step();
    end
    chk("f1_sequence_errors", bad, 0);
    chk("f1_frame_end", frame_end, 1);
    chk("f1_valid_low", pixel_valid, 0);
    chk("f1_frame_cnt", frame_cnt, 1);
    chk("f1_index_zero", pixel_index, 0);
`ifdef PIXEL_SCAN_XY_OUT_EN
    chk("f1_xy_zero", {pixel_x, pixel_y}, 0);
`endif
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (pixel_valid !== 1'b0 || frame_end !== 1'b0) bad++;
    end
    chk("f1_blank_16", bad, 0);
    step();
    chk("f2_valid", pixel_valid, 1);
    chk("f2_index", pixel_index, 0);
    chk("f2_frame_begin", frame_begin, 1);

    // Frame 2: random backpressure; the index model advances only on accepted beats.
    exp_idx = 0; accepts = 0; cycles = 0; bad = 0;
    while (accepts < 6144 && cycles < 40000) begin
      if (pixel_valid !== 1'b1 || pixel_index !== 13'(exp_idx)) bad++;
      pixel_ready = 1'($urandom_range(0, 1));
      step();
      cycles++;
      if (pixel_ready) begin
        accepts++;
        exp_idx = (exp_idx == 6143) ? 0 : exp_idx + 1;
      end
    end
    chk("f2_accepts", accepts, 6144);
    chk("f2_backpressure_errors", bad, 0);
    chk("f2_frame_end", frame_end, 1);
    chk("f2_frame_cnt", frame_cnt, 2);
    pixel_ready = 1'b1;

    // Enable dropped mid-frame: the frame still runs to the last index.
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    exp_idx = 0; cycles = 0; bad = 0;
    while (frame_end !== 1'b1 && cycles < 7000) begin
      if (pixel_valid !== 1'b1 || pixel_index !== 13'(exp_idx)) bad++;
      if (exp_idx == 3000) enable = 1'b0;
      exp_idx++;
      step();
      cycles++;
    end
    chk("drop_accepts", exp_idx, 6144);
    chk("drop_seq_errors", bad, 0);
    chk("drop_frame_cnt", frame_cnt, 1);
    repeat (15) step();
    chk("drop_blank_busy", busy, 1);
    step();
    chk("drop_idle_busy", busy, 0);
    chk("drop_idle_valid", pixel_valid, 0);
    repeat (3) step();
    chk("drop_stays_idle", {busy, pixel_valid}, 0);

    // Asynchronous reset at index 1234.
    enable = 1'b1;
    step();
    cycles = 0;
    while (pixel_index !== 13'd1234 && cycles < 2000) begin
      step();
      cycles++;
    end
    chk("ar_reach_1234", pixel_index, 1234);
    #2 reset = 1'b1;
    #1;
    chk("ar_valid", pixel_valid, 0);
    chk("ar_index", pixel_index, 0);
    chk("ar_cnt", frame_cnt, 0);
    chk("ar_busy", busy, 0);
    fe_seen = 0;
    repeat (2) begin
      step();
      if (frame_end !== 1'b0) fe_seen++;
    end
    chk("ar_no_frame_end", fe_seen, 0);
    reset = 1'b0;
    step();
    chk("ar_restart_valid", pixel_valid, 1);
    chk("ar_restart_index", pixel_index, 0);
    chk("ar_restart_begin", frame_begin, 1);
    repeat (3) step();
    chk("ar_restart_adv", pixel_index, 3);

    // Tiny 4x2 frame, one blank clock: 256 frames to wrap the counter.
    s_reset = 1'b0;
    step();
    s_enable = 1'b1; s_ready = 1'b1;
    step();
    bad = 0;
    for (int f = 1; f <= 256; f++) begin
      for (int p = 0; p < 8; p++) begin
        if (s_valid !== 1'b1 || s_idx !== 3'(p) || s_frame_begin !== (p == 0)) bad++;
        step();
      end
      if (s_frame_end !== 1'b1 || s_valid !== 1'b0 || s_cnt !== 8'(f)) bad++;
      if (f == 255) chk("wrap_255", s_cnt, 255);
      if (f == 256) chk("wrap_0", s_cnt, 0);
      step();
    end
    chk("small_seq_errors", bad, 0);
    chk("one_blank_gap", s_valid, 1);
    chk("one_blank_begin", s_frame_begin, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
